multiplier_controller_taint: RTL and testbench



---
 rtl/multiplier_controller_taint.sv | 164 ++++++++++++++++
 tb/tb_multiplier_controller_taint.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_controller_taint.sv
// Control FSM for the shift-add multiplier datapath, with taint propagated from start_t and
// multiplier bits into every strobe and into completion timing.
module multiplier_controller_taint #(
    parameter int unsigned WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             mdld,
    output logic             mrld,
    output logic             rsclear,
    output logic             rsload,
    output logic             rsshr,
    output logic             mdld_t,
    output logic             mrld_t,
    output logic             rsclear_t,
    output logic             rsload_t,
    output logic             rsshr_t,
    output logic             busy,
    output logic             done,
    output logic             done_t
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   count_q;
    logic            ctrl_t_q;

    logic            mdld_q, mrld_q, rsclear_q, rsload_q, rsshr_q;
    logic            mdld_t_q, mrld_t_q, rsclear_t_q, rsload_t_q, rsshr_t_q;
    logic            busy_q, done_q, done_t_q;

    logic [IW-1:0]   bit_idx;
    logic            cur_bit;
    logic            chk_t;

    // Multiplier is never shifted: the bit under test is picked by the counter.
    always_comb begin
        bit_idx = count_q[IW-1:0];
        cur_bit = multiplierReg[bit_idx];
        chk_t   = ctrl_t_q | multiplierReg_t[bit_idx];
    end

    // State, counter and taint, with outputs registered for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            ctrl_t_q    <= 1'b0;
            mdld_q      <= 1'b0;
            mrld_q      <= 1'b0;
            rsclear_q   <= 1'b0;
            rsload_q    <= 1'b0;
            rsshr_q     <= 1'b0;
            mdld_t_q    <= 1'b0;
            mrld_t_q    <= 1'b0;
            rsclear_t_q <= 1'b0;
            rsload_t_q  <= 1'b0;
            rsshr_t_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_t_q    <= 1'b0;
        end else begin
            mdld_q      <= 1'b0;
            mrld_q      <= 1'b0;
            rsclear_q   <= 1'b0;
            rsload_q    <= 1'b0;
            rsshr_q     <= 1'b0;
            mdld_t_q    <= 1'b0;
            mrld_t_q    <= 1'b0;
            rsclear_t_q <= 1'b0;
            rsload_t_q  <= 1'b0;
            rsshr_t_q   <= 1'b0;
            done_q      <= 1'b0;
            done_t_q    <= 1'b0;
            busy_q      <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    ctrl_t_q <= start_t;
                    if (start) begin
                        state_q     <= S_LOAD;
                        mdld_q      <= 1'b1;
                        mrld_q      <= 1'b1;
                        rsclear_q   <= 1'b1;
                        mdld_t_q    <= start_t;
                        mrld_t_q    <= start_t;
                        rsclear_t_q <= start_t;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    count_q <= '0;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    ctrl_t_q <= chk_t;
                    if (cur_bit) begin
                        state_q    <= S_ADD;
                        rsload_q   <= 1'b1;
                        rsload_t_q <= chk_t;
                    end else begin
                        state_q   <= S_SHIFT;
                        rsshr_q   <= 1'b1;
                        rsshr_t_q <= chk_t;
                    end
                end
                S_ADD: begin
                    state_q   <= S_SHIFT;
                    rsshr_q   <= 1'b1;
                    rsshr_t_q <= ctrl_t_q;
                end
                S_SHIFT: begin
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        done_t_q <= ctrl_t_q;
                    end else begin
                        count_q <= count_q + CW'(1);
                        state_q <= S_CHECK;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mdld      = mdld_q;
    assign mrld      = mrld_q;
    assign rsclear   = rsclear_q;
    assign rsload    = rsload_q;
    assign rsshr     = rsshr_q;
    assign mdld_t    = mdld_t_q;
    assign mrld_t    = mrld_t_q;
    assign rsclear_t = rsclear_t_q;
    assign rsload_t  = rsload_t_q;
    assign rsshr_t   = rsshr_t_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_t    = done_t_q;

endmodule

// File: tb/tb_multiplier_controller_taint.sv
// Bench for multiplier_controller_taint (WIDTH=4): directed table, corner sequences and
// random operations checked cycle by cycle against a trace model.
module tb_multiplier_controller_taint;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         start_t;
    logic [W-1:0] multiplierReg;
    logic [W-1:0] multiplierReg_t;
    logic         mdld, mrld, rsclear, rsload, rsshr;
    logic         mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t;
    logic         busy, done, done_t;

    multiplier_controller_taint #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_t         (start_t),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .mdld            (mdld),
        .mrld            (mrld),
        .rsclear         (rsclear),
        .rsload          (rsload),
        .rsshr           (rsshr),
        .mdld_t          (mdld_t),
        .mrld_t          (mrld_t),
        .rsclear_t       (rsclear_t),
        .rsload_t        (rsload_t),
        .rsshr_t         (rsshr_t),
        .busy            (busy),
        .done            (done),
        .done_t          (done_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Output vector: {busy, done, done_t, mdld, mrld, rsclear, rsload, rsshr, 5 taints}
    logic [12:0] exp_q[$];

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] mt;
        logic         st;
        int           lat;
        int           adds;
        logic         dt;
    } vec_t;

    function automatic logic [12:0] obs();
        return {busy, done, done_t, mdld, mrld, rsclear, rsload, rsshr,
                mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t};
    endfunction

    function automatic logic [12:0] mk(input logic ld, input logic ad, input logic sh,
                                       input logic dn, input logic t);
        return {1'b1, dn, dn & t, ld, ld, ld, ad, sh, ld & t, ld & t, ld & t, ad & t, sh & t};
    endfunction

    task automatic check(input string name, input logic [31:0] exp, input logic [31:0] act);
        n_checks++;
        if (exp !== act) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle expectation from LOAD through DONE: one CHECK per bit, an ADD for each 1 bit,
    // a SHIFT per bit; taint accumulates from start_t and each examined multiplier bit.
    task automatic build(input logic [W-1:0] m, input logic [W-1:0] mt, input logic st);
        logic t;
        exp_q.delete();
        t = st;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, t));
        for (int i = 0; i < int'(W); i++) begin
            t = t | mt[i];
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, t));
            if (m[i]) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, t));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, t));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE; start pulses for one cycle, start_t then scrambled.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] mt, input logic st,
                          output int lat, output int adds, output logic dt);
        multiplierReg   = m;
        multiplierReg_t = mt;
        start           = 1'b1;
        start_t         = st;
        tick();
        start   = 1'b0;
        start_t = 1'($urandom);
        build(m, mt, st);
        lat  = -1;
        adds = 0;
        dt   = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            check("trace", 32'(exp_q[k]), 32'(obs()));
            if (rsload) adds++;
            if (done) begin
                lat = k;
                dt  = done_t;
            end
            tick();
        end
        check("idle_after_done", 32'd0, 32'(obs()));
    endtask

    vec_t vecs[7];

    initial begin
        int   lat;
        int   adds;
        logic dt;
        int   waited;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{m: 4'b1011, mt: 4'b0000, st: 1'b0, lat: 12, adds: 3, dt: 1'b0};
        vecs[1] = '{m: 4'b0000, mt: 4'b0000, st: 1'b0, lat: 9,  adds: 0, dt: 1'b0};
        vecs[2] = '{m: 4'b1111, mt: 4'b0000, st: 1'b0, lat: 13, adds: 4, dt: 1'b0};
        vecs[3] = '{m: 4'b0101, mt: 4'b0100, st: 1'b0, lat: 11, adds: 2, dt: 1'b1};
        vecs[4] = '{m: 4'b0110, mt: 4'b0000, st: 1'b1, lat: 11, adds: 2, dt: 1'b1};
        vecs[5] = '{m: 4'b1101, mt: 4'b0000, st: 1'b0, lat: 12, adds: 3, dt: 1'b0};
        vecs[6] = '{m: 4'b1000, mt: 4'b0001, st: 1'b0, lat: 10, adds: 1, dt: 1'b1};

        rst_n           = 1'b0;
        start           = 1'b0;
        start_t         = 1'b0;
        multiplierReg   = '0;
        multiplierReg_t = '0;
        #2;
        check("reset_outputs", 32'd0, 32'(obs()));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 32'd0, 32'(obs()));

        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].m, vecs[v].mt, vecs[v].st, lat, adds, dt);
            check("latency", 32'(vecs[v].lat), 32'(lat));
            check("rsload_count", 32'(vecs[v].adds), 32'(adds));
            check("done_t", 32'(vecs[v].dt), 32'(dt));
        end

        // Asynchronous reset during the second ADD of 1011.
        multiplierReg   = 4'b1011;
        multiplierReg_t = 4'b0000;
        start           = 1'b1;
        start_t         = 1'b0;
        tick();
        start = 1'b0;
        build(4'b1011, 4'b0000, 1'b0);
        for (int k = 0; k < 6; k++) begin
            check("pre_reset_trace", 32'(exp_q[k]), 32'(obs()));
            if (k < 5) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", 32'd0, 32'(obs()));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_post_reset", 32'd0, 32'(obs()));
        run_op(4'b1011, 4'b0000, 1'b0, lat, adds, dt);
        check("post_reset_latency", 32'd12, 32'(lat));

        // start held high: no restart while busy, immediate relaunch after DONE.
        multiplierReg   = 4'b0010;
        multiplierReg_t = 4'b0000;
        start           = 1'b1;
        start_t         = 1'b1;
        tick();
        start_t = 1'b0;
        build(4'b0010, 4'b0000, 1'b1);
        for (int k = 0; k < exp_q.size(); k++) begin
            check("held_start_trace", 32'(exp_q[k]), 32'(obs()));
            tick();
        end
        check("held_start_idle", 32'd0, 32'(obs()));
        tick();
        check("held_start_relaunch", 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)), 32'(obs()));
        start  = 1'b0;
        waited = 0;
        while (!done && waited < 40) begin
            tick();
            waited++;
        end
        check("relaunch_done_seen", 32'd1, 32'(done));
        tick();
        check("relaunch_idle", 32'd0, 32'(obs()));

        for (int r = 0; r < 25; r++) begin
            logic [W-1:0] m;
            logic [W-1:0] mt;
            logic         st;
            m  = W'($urandom);
            mt = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            st = ($urandom_range(0, 3) == 0);
            run_op(m, mt, st, lat, adds, dt);
            check("rand_latency", 32'(2 * W + $countones(m) + 1), 32'(lat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
